// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory each cycle in RUN and
// queues {PC, instruction} pairs for decode over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic                        Halt,
    input  logic                        RedirectValid,
    input  logic [31:0]                 RedirectPC,
    output logic [31:0]                 IMemAddress,
    input  logic [31:0]                 IMemInstruction,
    output logic                        FetchValid,
    input  logic                        FetchReady,
    output logic [31:0]                 FetchInstruction,
    output logic [31:0]                 FetchPC,
    output logic [$clog2(FIFO_DEPTH):0] FetchCount,
    output logic                        Running
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e          state_q;
    logic [31:0]     pc_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [31:0]     pc_mem    [FIFO_DEPTH];
    logic [31:0]     instr_mem [FIFO_DEPTH];

    logic has_entry;
    logic pop;
    logic fetch;

    assign has_entry = (count_q != '0);
    // A redirect hides the head so decode never consumes a wrong-path entry.
    assign FetchValid       = has_entry && !RedirectValid;
    assign pop              = FetchValid && FetchReady;
    assign fetch            = (state_q == StRun) && !RedirectValid && !Halt &&
                              ((count_q < CW'(FIFO_DEPTH)) || pop);
    assign FetchInstruction = has_entry ? instr_mem[rd_ptr_q] : 32'h0;
    assign FetchPC          = has_entry ? pc_mem[rd_ptr_q] : 32'h0;
    assign FetchCount       = count_q;
    assign IMemAddress      = pc_q;
    assign Running          = (state_q == StRun);

    // Queue storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge Clk) begin
        if (fetch) begin
            pc_mem[wr_ptr_q]    <= pc_q;
            instr_mem[wr_ptr_q] <= IMemInstruction;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        state_q <= StRun;
                        pc_q    <= RESET_PC;
                    end
                end
                StRun: begin
                    if (Halt) state_q <= StHalted;
                end
                StHalted: begin
                    if (Start) state_q <= StRun;
                end
                default: state_q <= StIdle;
            endcase

            if (RedirectValid) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                pc_q     <= {RedirectPC[31:2], 2'b00};
            end else begin
                if (fetch) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                    pc_q     <= pc_q + 32'd4;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
                if (fetch && !pop) begin
                    count_q <= count_q + CW'(1);
                end else if (!fetch && pop) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; instruction memory returns address >> 2.
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic        Halt;
    logic        RedirectValid;
    logic [31:0] RedirectPC;
    logic [31:0] IMemAddress;
    logic [31:0] IMemInstruction;
    logic        FetchValid;
    logic        FetchReady;
    logic [31:0] FetchInstruction;
    logic [31:0] FetchPC;
    logic [2:0]  FetchCount;
    logic        Running;

    int n_cmp;
    int n_err;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(4)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Start           (Start),
        .Halt            (Halt),
        .RedirectValid   (RedirectValid),
        .RedirectPC      (RedirectPC),
        .IMemAddress     (IMemAddress),
        .IMemInstruction (IMemInstruction),
        .FetchValid      (FetchValid),
        .FetchReady      (FetchReady),
        .FetchInstruction(FetchInstruction),
        .FetchPC         (FetchPC),
        .FetchCount      (FetchCount),
        .Running         (Running)
    );

    assign IMemInstruction = IMemAddress >> 2;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow a further 1 unit.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        settle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Rst = 1'b0;
        Start = 1'b0;
        Halt = 1'b0;
        RedirectValid = 1'b0;
        RedirectPC = 32'h0;
        FetchReady = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_valid", 32'(FetchValid), 32'd0);
        check_eq("rst_count", 32'(FetchCount), 32'd0);
        check_eq("rst_addr", IMemAddress, 32'h0);
        check_eq("rst_running", 32'(Running), 32'd0);
        check_eq("rst_pc", FetchPC, 32'h0);
        check_eq("rst_instr", FetchInstruction, 32'h0);
        Rst = 1'b1;

        // 1: back-to-back streaming
        tick();
        Start = 1'b1;
        FetchReady = 1'b1;
        tick();
        Start = 1'b0;
        settle();
        check_eq("t1_running", 32'(Running), 32'd1);
        check_eq("t1_valid0", 32'(FetchValid), 32'd0);
        check_eq("t1_addr0", IMemAddress, 32'h0);
        tick();
        check_eq("t1_valid1", 32'(FetchValid), 32'd1);
        check_eq("t1_pc0", FetchPC, 32'h0);
        check_eq("t1_instr0", FetchInstruction, 32'h0);
        check_eq("t1_addr1", IMemAddress, 32'h4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("t1_pc", FetchPC, 32'(4 * i));
            check_eq("t1_instr", FetchInstruction, 32'(i));
            check_eq("t1_count", 32'(FetchCount), 32'd1);
        end

        // 2: saturation then 1-in/1-out
        do_reset();
        FetchReady = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("t2_count_full", 32'(FetchCount), 32'd4);
        check_eq("t2_addr_hold", IMemAddress, 32'h10);
        check_eq("t2_head", FetchPC, 32'h0);
        FetchReady = 1'b1;
        tick();
        check_eq("t2_count_a", 32'(FetchCount), 32'd4);
        check_eq("t2_head_a", FetchPC, 32'h4);
        check_eq("t2_addr_a", IMemAddress, 32'h14);
        tick();
        check_eq("t2_count_b", 32'(FetchCount), 32'd4);
        check_eq("t2_head_b", FetchPC, 32'h8);

        // 3: redirect flushes a 3-entry queue
        do_reset();
        FetchReady = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("t3_count3", 32'(FetchCount), 32'd3);
        RedirectValid = 1'b1;
        RedirectPC = 32'h0000_0103;
        settle();
        check_eq("t3_valid_masked", 32'(FetchValid), 32'd0);
        tick();
        RedirectValid = 1'b0;
        settle();
        check_eq("t3_count_flush", 32'(FetchCount), 32'd0);
        check_eq("t3_addr", IMemAddress, 32'h100);
        FetchReady = 1'b1;
        tick();
        check_eq("t3_valid", 32'(FetchValid), 32'd1);
        check_eq("t3_pc", FetchPC, 32'h100);
        check_eq("t3_instr", FetchInstruction, 32'h40);

        // 4: halt drains the queue, start resumes at the frozen PC
        FetchReady = 1'b0;
        tick();
        check_eq("t4_count2", 32'(FetchCount), 32'd2);
        Halt = 1'b1;
        FetchReady = 1'b1;
        tick();
        Halt = 1'b0;
        settle();
        check_eq("t4_running", 32'(Running), 32'd0);
        check_eq("t4_count1", 32'(FetchCount), 32'd1);
        check_eq("t4_head", FetchPC, 32'h104);
        check_eq("t4_addr_a", IMemAddress, 32'h108);
        tick();
        check_eq("t4_count0", 32'(FetchCount), 32'd0);
        check_eq("t4_valid0", 32'(FetchValid), 32'd0);
        tick();
        check_eq("t4_addr_b", IMemAddress, 32'h108);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        settle();
        check_eq("t4_running2", 32'(Running), 32'd1);
        check_eq("t4_count_r", 32'(FetchCount), 32'd0);
        tick();
        check_eq("t4_pc_resume", FetchPC, 32'h108);
        check_eq("t4_instr_resume", FetchInstruction, 32'h42);
        check_eq("t4_addr_c", IMemAddress, 32'h10C);

        // 5: PC wraps past the top of the address space
        RedirectValid = 1'b1;
        RedirectPC = 32'hFFFF_FFF8;
        tick();
        RedirectValid = 1'b0;
        settle();
        check_eq("t5_addr", IMemAddress, 32'hFFFF_FFF8);
        check_eq("t5_count", 32'(FetchCount), 32'd0);
        tick();
        check_eq("t5_pc0", FetchPC, 32'hFFFF_FFF8);
        check_eq("t5_instr0", FetchInstruction, 32'h3FFF_FFFE);
        tick();
        check_eq("t5_pc1", FetchPC, 32'hFFFF_FFFC);
        check_eq("t5_instr1", FetchInstruction, 32'h3FFF_FFFF);
        check_eq("t5_addr_wrap", IMemAddress, 32'h0);
        tick();
        check_eq("t5_pc2", FetchPC, 32'h0);
        check_eq("t5_instr2", FetchInstruction, 32'h0);

        // 6: asynchronous reset with a full queue
        FetchReady = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("t6_full", 32'(FetchCount), 32'd4);
        @(negedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        check_eq("t6_valid", 32'(FetchValid), 32'd0);
        check_eq("t6_count", 32'(FetchCount), 32'd0);
        check_eq("t6_addr", IMemAddress, 32'h0);
        check_eq("t6_running", 32'(Running), 32'd0);
        check_eq("t6_pc", FetchPC, 32'h0);
        tick();
        Rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
